bsg_front_side_bus_hop_in_fc: RTL

//  Flow-controlled, parametrised successor of the no-flow-control FSB hop-in stage.

---
 rtl/bsg_front_side_bus_hop_in_fc_pkg.sv | 15 +
 rtl/bsg_front_side_bus_hop_in_fc_fifo.sv | 57 +++++
 rtl/bsg_front_side_bus_hop_in_fc.sv | 63 ++++++
 3 files changed

// File: rtl/bsg_front_side_bus_hop_in_fc_pkg.sv
// Shared constants/helpers for the flow-controlled FSB hop-in stage.
// Entry layout: {local accept bits, data}; mask bit 0 (next hop) is implicit.
package bsg_front_side_bus_hop_in_fc_pkg;

  localparam int unsigned def_width_lp   = 16;
  localparam int unsigned def_fan_out_lp = 2;

  function automatic int unsigned entry_width(
    input int unsigned width,
    input int unsigned fan_out
  );
    return width + fan_out - 1;
  endfunction

endpackage

// File: rtl/bsg_front_side_bus_hop_in_fc_fifo.sv
// bsg_two_fifo: 2-entry registered FIFO, head is driven straight from a flop.
// Ports: data_i/v_i/ready_o in, data_o/v_o out, yumi_i pops the head.
module bsg_two_fifo #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic [width_p-1:0] mem_d [2];
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               enq, deq;

  // Full blocks input even if the head pops this cycle.
  assign ready_o = (cnt_q != 2'd2) & ~reset_i;
  assign v_o     = (cnt_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + {1'b0, enq} - {1'b0, deq};
    if (enq) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ~wptr_q;
    end
    if (deq) begin
      rptr_d = ~rptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (reset_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bsg_front_side_bus_hop_in_fc.sv
// Flow-controlled FSB hop-in: buffers one stream, multicasts to fan_out_p consumers.
// Ports: data_i/v_i/ready_o/local_accept_i in; data_o/v_o/ready_i per consumer out.
module bsg_front_side_bus_hop_in_fc
  import bsg_front_side_bus_hop_in_fc_pkg::*;
#(
  parameter int unsigned width_p   = def_width_lp,
  parameter int unsigned fan_out_p = def_fan_out_lp
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [width_p-1:0]             data_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [fan_out_p-2:0]           local_accept_i,
  output logic [fan_out_p*width_p-1:0]   data_o,
  output logic [fan_out_p-1:0]           v_o,
  input  logic [fan_out_p-1:0]           ready_i
);

  localparam int unsigned ew_lp = entry_width(width_p, fan_out_p);

  logic [ew_lp-1:0]     in_entry;
  logic [ew_lp-1:0]     head_entry;
  logic                 head_v;
  logic [width_p-1:0]   head_data;
  logic [fan_out_p-1:0] mask;
  logic [fan_out_p-1:0] fire;
  logic [fan_out_p-1:0] sent_q, sent_d;
  logic                 done;

  assign in_entry = {local_accept_i, data_i};

  bsg_two_fifo #(
    .width_p (ew_lp)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (in_entry),
    .v_i     (v_i),
    .ready_o (ready_o),
    .data_o  (head_entry),
    .v_o     (head_v),
    .yumi_i  (done)
  );

  assign head_data = head_entry[width_p-1:0];
  assign mask      = {head_entry[ew_lp-1:width_p], 1'b1};
  assign data_o    = {fan_out_p{head_data}};

  // A consumer that already took the head drops its valid.
  always_comb begin
    v_o    = {fan_out_p{head_v}} & mask & ~sent_q;
    fire   = v_o & ready_i;
    done   = head_v & ((mask & ~(sent_q | fire)) == '0);
    sent_d = done ? '0 : (sent_q | fire);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) sent_q <= '0;
    else         sent_q <= sent_d;
  end

endmodule
